// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: data width, buffered fetch entry and the canonical NOP.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO of fetched {addr, data} entries with a single-cycle flush.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  fetch_entry_t                 push_entry,
   input  logic                         pop,
   input  logic                         flush,
   output logic                         full,
   output logic                         empty,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;

   // NOTE: storage is deliberately not reset; count/pointers alone decide which slots are live.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wptr] <= push_entry;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem[rptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: prefetches sequential words ahead of pc and flushes on any pc mismatch.
module ifetch_buffer
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic            fetch_misaligned,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0] nf;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop;

   fetch_entry_t    head;
   fetch_entry_t    push_entry;
   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic            fifo_full;

   logic            aligned;
   logic            redirect;
   logic            pop;
   logic            push;
   logic            req_fire;
   logic            resp_accept;
   logic [CW-1:0]   live;
   logic [CW:0]     in_use;
   logic [XLEN-1:0] resp_addr;

   assign aligned          = (pc[1:0] == 2'b00);
   assign fetch_misaligned = reset && !aligned;
   assign instr_valid      = reset && aligned && !fifo_empty && (head.addr == pc);
   assign instr            = instr_valid ? head.data : '0;
   assign pop              = instr_valid;

   // A misaligned pc freezes the buffer rather than treating it as a jump target.
   assign redirect = reset && aligned &&
                     (( !fifo_empty && (head.addr != pc)) ||
                      (  fifo_empty && (outstanding == '0) && (nf != pc)));

   // The slot freed by this cycle's pop is credited so a full stream sustains one word per cycle.
   assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
   assign mem_req  = reset && aligned && !redirect && (in_use < DEPTH_W);
   assign mem_addr = nf;
   assign req_fire = mem_req && mem_gnt;

   // Responses with nothing outstanding belong to requests abandoned by reset.
   assign resp_accept = mem_rvalid && (outstanding != '0);

   // Live requests were issued contiguously and end just below nf, so the oldest one's address is implied.
   assign live       = outstanding - drop;
   assign resp_addr  = nf - {{(XLEN-CW-2){1'b0}}, live, 2'b00};
   assign push       = resp_accept && (drop == '0) && !redirect && !fifo_full;
   assign push_entry = '{addr: resp_addr, data: mem_rdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nf          <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect) begin
         nf          <= pc;
         outstanding <= outstanding - CW'(resp_accept);
         drop        <= outstanding - CW'(resp_accept);
      end else begin
         if (req_fire) nf <= nf + 32'd4;
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_accept);
         if (resp_accept && (drop != '0)) drop <= drop - 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: in-order memory model returning addr|1 one cycle after grant.
module tb_ifetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_misaligned;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int          checks = 0;
   int          errors = 0;
   logic        hold   = 1'b0;
   logic [31:0] q[$];

   typedef struct {
      logic [31:0] pc;
      logic        gnt;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[6];

   ifetch_buffer #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pc               (pc),
      .instr            (instr),
      .instr_valid      (instr_valid),
      .fetch_misaligned (fetch_misaligned),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_gnt          (mem_gnt),
      .mem_rvalid       (mem_rvalid),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic refresh();
      mem_rvalid = !hold && (q.size() != 0);
      mem_rdata  = mem_rvalid ? (q[0] | 32'h1) : 32'h0;
   endtask

   task automatic set_hold(input logic b);
      hold = b;
      refresh();
   endtask

   // Advance one clock; the memory model records the handshakes seen just before the edge.
   task automatic adv();
      logic        took;
      logic        gave;
      logic [31:0] ta;
      took = mem_req && mem_gnt;
      gave = mem_rvalid;
      ta   = mem_addr;
      @(posedge clk);
      #1;
      if (gave) void'(q.pop_front());
      if (took) q.push_back(ta);
      refresh();
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic mis);
      check({tag, " mem_req"}, {31'b0, mem_req}, {31'b0, req});
      if (req) check({tag, " mem_addr"}, mem_addr, addr);
      check({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, valid});
      check({tag, " instr"}, instr, ins);
      check({tag, " misaligned"}, {31'b0, fetch_misaligned}, {31'b0, mis});
   endtask

   task automatic cyc(input string tag, input logic [31:0] p, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] ins, input logic mis = 1'b0);
      pc = p;
      #1;
      expect_out(tag, req, addr, valid, ins, mis);
      adv();
   endtask

   initial begin
      vecs[0] = '{32'h00, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1] = '{32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2] = '{32'h00, 1'b1, 1'b1, 32'h08, 1'b1, 32'h01};
      vecs[3] = '{32'h04, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h05};
      vecs[4] = '{32'h08, 1'b1, 1'b1, 32'h10, 1'b1, 32'h09};
      vecs[5] = '{32'h0C, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0D};

      reset      = 1'b0;
      pc         = 32'h6;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      #1;
      expect_out("in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("in_reset mem_addr", mem_addr, 32'h0);
      pc = 32'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Start-up stream: first word valid on the third cycle, then one per cycle.
      for (int i = 0; i < 6; i++) begin
         mem_gnt = vecs[i].gnt;
         cyc($sformatf("stream%0d", i), vecs[i].pc, vecs[i].exp_req, vecs[i].exp_addr,
             vecs[i].exp_valid, vecs[i].exp_instr);
      end

      // Jump 0x10 -> 0x100 with two requests in flight.
      set_hold(1'b1);
      cyc("jmp_g", 32'h10,  1'b1, 32'h18,  1'b1, 32'h11);
      set_hold(1'b0);
      cyc("jmp_h", 32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
      cyc("jmp_redir", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc("jmp_n1", 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
      cyc("jmp_n2", 32'h100, 1'b1, 32'h104, 1'b0, 32'h0);
      set_hold(1'b1);
      cyc("jmp_n3", 32'h100, 1'b1, 32'h108, 1'b1, 32'h101);

      // Redirect while a response is still owed: it must be dropped, not shown.
      set_hold(1'b0);
      cyc("drop_m", 32'h104, 1'b0, 32'h0,   1'b0, 32'h0);
      set_hold(1'b1);
      cyc("drop_redir", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc("drop_o", 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
      set_hold(1'b0);
      cyc("drop_p", 32'h200, 1'b0, 32'h0,   1'b0, 32'h0);
      cyc("drop_q", 32'h200, 1'b1, 32'h204, 1'b0, 32'h0);

      // Grant held low for five cycles.
      mem_gnt = 1'b0;
      cyc("gnt_r", 32'h200, 1'b1, 32'h208, 1'b1, 32'h201);
      cyc("gnt_s", 32'h204, 1'b1, 32'h208, 1'b1, 32'h205);
      for (int i = 0; i < 3; i++) cyc($sformatf("gnt_hold%0d", i), 32'h208, 1'b1, 32'h208, 1'b0, 32'h0);
      mem_gnt = 1'b1;
      cyc("gnt_w", 32'h208, 1'b1, 32'h208, 1'b0, 32'h0);
      cyc("gnt_x", 32'h208, 1'b1, 32'h20C, 1'b0, 32'h0);
      cyc("gnt_y", 32'h208, 1'b1, 32'h210, 1'b1, 32'h209);

      // Misaligned pc freezes the buffer; realigned pc finds it intact, then pc=0x8 redirects.
      cyc("mis_1", 32'h6,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1);
      cyc("mis_2", 32'h6,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1);
      cyc("mis_keep", 32'h20C, 1'b1, 32'h214, 1'b1, 32'h20D);
      cyc("mis_redir", 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc("mis_n1", 32'h8, 1'b1, 32'h8,  1'b0, 32'h0);
      cyc("mis_n2", 32'h8, 1'b1, 32'hC,  1'b0, 32'h0);
      cyc("mis_n3", 32'h8, 1'b1, 32'h10, 1'b1, 32'h9);

      // Address wrap at the top of memory.
      cyc("wrap_redir", 32'hFFFF_FFF8, 1'b0, 32'h0,         1'b0, 32'h0);
      cyc("wrap_1",     32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
      cyc("wrap_2",     32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      cyc("wrap_3",     32'hFFFF_FFF8, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF9);
      cyc("wrap_4",     32'hFFFF_FFFC, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFD);
      cyc("wrap_5",     32'h0000_0000, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0001);

      // Reset with two requests in flight; their late responses must be ignored.
      set_hold(1'b1);
      cyc("rst_pre", 32'h4, 1'b1, 32'hC, 1'b1, 32'h5);
      reset = 1'b0;
      pc    = 32'h6;
      #1;
      expect_out("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("rst_mid mem_addr", mem_addr, 32'h0);
      adv();
      reset   = 1'b1;
      mem_gnt = 1'b0;
      set_hold(1'b0);
      cyc("rst_late1", 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      cyc("rst_late2", 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      mem_gnt = 1'b1;
      cyc("rst_first", 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      cyc("rst_second", 32'h0, 1'b1, 32'h4, 1'b0, 32'h0);
      cyc("rst_valid", 32'h0, 1'b1, 32'h8, 1'b1, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: buffer entries and maximum outstanding requests (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pc, input, 32: address of the instruction the core executes this cycle.
REQ-006 SHALL have port instr, output, 32: instruction word for pc, meaningful only when instr_valid=1.
REQ-007 SHALL have port instr_valid, output, 1: instr matches pc; the core stalls while low.
REQ-008 SHALL have port fetch_misaligned, output, 1: pc[1:0] != 0.
REQ-009 SHALL have ports mem_req (output, 1), mem_addr (output, 32) and mem_gnt (input, 1) as the request channel; transfer when mem_req & mem_gnt.
REQ-010 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, 32) as the in-order response channel, without backpressure.

Function
REQ-011 Buffer SHALL be a FIFO of DEPTH entries {addr[31:0], data[31:0]}; fetch pointer nf SHALL hold the next request address.
REQ-012 instr_valid SHALL be 1 iff buffer non-empty, head.addr == pc and pc[1:0] == 0; instr = head.data, else 32'h0.
REQ-013 Head SHALL pop on every rising edge where instr_valid=1; a single-cycle core consumes every valid cycle.
REQ-014 mem_req SHALL be 1 iff (occupancy + outstanding) < DEPTH, no redirect this cycle and pc[1:0] == 0; mem_addr = nf.
REQ-015 On request transfer: nf <= nf + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); outstanding increments.
REQ-016 Each mem_rvalid SHALL decrement outstanding and push {issued addr, mem_rdata}, unless drop count > 0; then discard it and decrement drop.
REQ-017 Redirect SHALL be detected when (buffer non-empty and head.addr != pc) or (buffer empty, outstanding == 0 and nf != pc).
REQ-018 On redirect: flush all entries; nf <= pc; drop <= outstanding minus any response accepted that cycle; mem_req = 0 that cycle.
REQ-019 No bypass: response data SHALL appear on instr one cycle after mem_rvalid.
REQ-020 Redirect-to-instr_valid latency with gnt and rvalid each one cycle after the previous event: 3 cycles (redirect N, req/gnt N+1, rvalid N+2, valid N+3).
REQ-021 Simultaneous push and pop SHALL both take effect; occupancy is unchanged.
REQ-022 Pop from a single-entry buffer plus a same-cycle request SHALL be allowed; occupancy never exceeds DEPTH.
REQ-023 Misaligned pc SHALL hold instr_valid=0 and fetch_misaligned=1 and suppress requests; buffer state is retained.

Reset
REQ-024 Reset assertion SHALL clear all entries, outstanding and drop to 0 and set nf to RESET_PC.
REQ-025 During reset: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, fetch_misaligned=0.
REQ-026 Reset mid-transaction SHALL abandon in-flight requests; responses after deassertion with outstanding == 0 are ignored.

Structure
REQ-027 Package riscv_pkg SHALL hold XLEN=32, the fetch-entry struct typedef and the NOP constant 32'h0000_0013.
REQ-028 Storage SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, head); ifetch_buffer holds nf, outstanding, drop and redirect logic.

Verification
REQ-029 Reset, pc=0, gnt=1, 1-cycle response, mem_rdata=addr|1 -> requests 0,4,8,...; instr_valid from cycle 3 after deassertion; one instruction per cycle thereafter.
REQ-030 Steady stream, then pc jumps 0x10 to 0x100 with 2 outstanding -> both stale responses dropped; next request addr 0x100; instr=0x101 three cycles later.
REQ-031 mem_gnt held low 5 cycles -> mem_req and mem_addr stable; instr_valid=0 once the buffer drains; no nf advance.
REQ-032 pc=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000; no X values, correct addr tags.
REQ-033 pc=0x6 -> fetch_misaligned=1, instr_valid=0, mem_req=0; pc=0x8 -> normal redirect.
REQ-034 Reset asserted with 2 outstanding, then 2 late rvalid pulses -> buffer stays empty; first request RESET_PC.
